// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_ctrl_if
// Description : Host request/response handshake plus word-array bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    localparam int c_NUM_WORDS = 2 ** ADDR_W;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_write;
    logic [DATA_W-1:0]      rsp_rdata;
    logic [c_NUM_WORDS-1:0] word_sel;
    logic                   read_write;
    logic [DATA_W-1:0]      ram_in;
    logic [DATA_W-1:0]      ram_out;

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_out,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, word_sel, read_write, ram_in
    );

    // Host and array side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_out,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, word_sel, read_write, ram_in
    );
endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_ctrl
// Description : Sequences setup/strobe/hold accesses on a word-organised RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_ctrl #(
    parameter int ADDR_W        = 2,
    parameter int DATA_W        = 4,
    parameter int STROBE_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ram_access_ctrl_if.slave   bus
);
    localparam int                     c_NUM_WORDS = 2 ** ADDR_W;
    localparam logic [3:0]             c_CNT_LOAD  = 4'(STROBE_CYCLES - 1);
    localparam logic [c_NUM_WORDS-1:0] c_SEL_ONE   = c_NUM_WORDS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_op_write;
    logic [ADDR_W-1:0]      r_op_addr;
    logic [DATA_W-1:0]      r_op_wdata;
    logic [3:0]             r_cnt;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic                   r_rsp_write;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic [c_NUM_WORDS-1:0] r_word_sel;
    logic                   r_read_write;
    logic [DATA_W-1:0]      r_ram_in;

    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_capture;
    logic [3:0]             w_cnt_nxt;
    logic                   w_op_write;
    logic [ADDR_W-1:0]      w_op_addr;
    logic [DATA_W-1:0]      w_op_wdata;
    logic                   w_busy_nxt;
    logic [c_NUM_WORDS-1:0] w_word_sel_nxt;
    logic                   w_read_write_nxt;
    logic [DATA_W-1:0]      w_ram_in_nxt;
    logic                   w_rsp_write_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_cnt_nxt   = c_CNT_LOAD;
                w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Array outputs are registered from the next state, so the freshly
        // latched request must be visible here on the accepting edge.
        w_op_write = w_accept ? bus.req_write : r_op_write;
        w_op_addr  = w_accept ? bus.req_addr  : r_op_addr;
        w_op_wdata = w_accept ? bus.req_wdata : r_op_wdata;

        w_busy_nxt       = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                           (w_state_nxt == S_HOLD);
        w_word_sel_nxt   = (w_state_nxt == S_STROBE) ? (c_SEL_ONE << w_op_addr) : '0;
        w_read_write_nxt = w_busy_nxt ? ~w_op_write : 1'b1;
        w_ram_in_nxt     = (w_busy_nxt && w_op_write) ? w_op_wdata : '0;
        w_rsp_write_nxt  = (r_state == S_HOLD) ? r_op_write : r_rsp_write;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_write   <= 1'b0;
            r_op_addr    <= '0;
            r_op_wdata   <= '0;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_word_sel   <= '0;
            r_read_write <= 1'b1;
            r_ram_in     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op_write   <= w_op_write;
            r_op_addr    <= w_op_addr;
            r_op_wdata   <= w_op_wdata;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_rsp_valid  <= (w_state_nxt == S_RESP);
            r_rsp_write  <= w_rsp_write_nxt;
            r_word_sel   <= w_word_sel_nxt;
            r_read_write <= w_read_write_nxt;
            r_ram_in     <= w_ram_in_nxt;
            if (w_capture) begin
                r_rsp_rdata <= r_op_write ? '0 : bus.ram_out;
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_write  = r_rsp_write;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.word_sel   = r_word_sel;
    assign bus.read_write = r_read_write;
    assign bus.ram_in     = r_ram_in;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_ctrl
// Description : Self-checking bench; two controllers (1 and 3 strobe cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_ctrl;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

    ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    logic       v1 = 1'b0, v3 = 1'b0;
    logic       t_write = 1'b0;
    logic [1:0] t_addr  = 2'd0;
    logic [3:0] t_wdata = 4'd0;
    logic       t_rsp_ready = 1'b1;

    assign bus1.req_valid = v1;      assign bus3.req_valid = v3;
    assign bus1.req_write = t_write; assign bus3.req_write = t_write;
    assign bus1.req_addr  = t_addr;  assign bus3.req_addr  = t_addr;
    assign bus1.req_wdata = t_wdata; assign bus3.req_wdata = t_wdata;
    assign bus1.rsp_ready = t_rsp_ready;
    assign bus3.rsp_ready = t_rsp_ready;

    // Behavioural 4x4 cell arrays driven by each controller's array bus.
    logic [3:0] arr1 [4] = '{4'h3, 4'h6, 4'h9, 4'hC};
    logic [3:0] arr3 [4] = '{4'h3, 4'h6, 4'h9, 4'hC};
    logic [3:0] ro1, ro3;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus1.word_sel[i] === 1'b1 && bus1.read_write === 1'b0) arr1[i] <= bus1.ram_in;
            if (bus3.word_sel[i] === 1'b1 && bus3.read_write === 1'b0) arr3[i] <= bus3.ram_in;
        end
    end
    always_comb begin
        ro1 = 4'h0;
        ro3 = 4'h0;
        for (int j = 0; j < 4; j++) begin
            if (bus1.word_sel[j] === 1'b1) ro1 = ro1 | arr1[j];
            if (bus3.word_sel[j] === 1'b1) ro3 = ro3 | arr3[j];
        end
    end
    assign bus1.ram_out = ro1;
    assign bus3.ram_out = ro3;

    // Observation mux onto whichever controller is under test.
    logic       sel3 = 1'b0;
    logic       mon_req_ready, mon_rsp_valid, mon_rsp_write, mon_rw;
    logic [3:0] mon_rdata, mon_word_sel, mon_ram_in;
    assign mon_req_ready = sel3 ? bus3.req_ready  : bus1.req_ready;
    assign mon_rsp_valid = sel3 ? bus3.rsp_valid  : bus1.rsp_valid;
    assign mon_rsp_write = sel3 ? bus3.rsp_write  : bus1.rsp_write;
    assign mon_rdata     = sel3 ? bus3.rsp_rdata  : bus1.rsp_rdata;
    assign mon_word_sel  = sel3 ? bus3.word_sel   : bus1.word_sel;
    assign mon_rw        = sel3 ? bus3.read_write : bus1.read_write;
    assign mon_ram_in    = sel3 ? bus3.ram_in     : bus1.ram_in;

    int n_pass = 0, n_checks = 0;
    int acc1 = 0, acc3 = 0, exp_acc1 = 0, exp_acc3 = 0;
    logic [3:0] ref1 [4];
    logic [3:0] ref3 [4];
    bit inv_en = 1'b0;

    always @(posedge clk) begin
        if (rst_n && v1 && bus1.req_ready) acc1 <= acc1 + 1;
        if (rst_n && v3 && bus3.req_ready) acc3 <= acc3 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            chk("onehot0 word_sel S1", 32'($onehot0(bus1.word_sel)), 1);
            chk("onehot0 word_sel S3", 32'($onehot0(bus3.word_sel)), 1);
            chk("sel while ready S1", 32'((bus1.word_sel != 0) && bus1.req_ready), 0);
            chk("sel while ready S3", 32'((bus3.word_sel != 0) && bus3.req_ready), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input bit s);
        sel3 = s;
        #1;
    endtask

    task automatic scramble();
        t_write = 1'($urandom);
        t_addr  = 2'($urandom);
        t_wdata = 4'($urandom);
    endtask

    task automatic do_op(input bit s3, input bit wr, input logic [1:0] a, input logic [3:0] d,
                         output logic [3:0] rd, output logic rw);
        int n;
        set_sel(s3);
        t_write = wr; t_addr = a; t_wdata = d;
        n = 0;
        while (!mon_req_ready && n < 50) begin tick(); n++; end
        if (s3) v3 = 1'b1; else v1 = 1'b1;
        tick();
        v1 = 1'b0; v3 = 1'b0;
        if (s3) exp_acc3++; else exp_acc1++;
        scramble();
        n = 0;
        while (!mon_rsp_valid && n < 50) begin tick(); n++; end
        chk("rsp_valid within budget", 32'(mon_rsp_valid), 1);
        rd = mon_rdata;
        rw = mon_rsp_write;
        tick();
    endtask

    // Scoreboard: a write stores into the expected image, a read returns it.
    task automatic model_op(input bit s3, input bit wr, input logic [1:0] a, input logic [3:0] d,
                            input string name);
        logic [3:0] rd, expd;
        logic       rw;
        expd = wr ? 4'h0 : (s3 ? ref3[a] : ref1[a]);
        do_op(s3, wr, a, d, rd, rw);
        chk({name, " rdata"}, 32'(rd), 32'(expd));
        chk({name, " rsp_write"}, 32'(rw), 32'(wr));
        if (wr) begin
            if (s3) ref3[a] = d; else ref1[a] = d;
        end
    endtask

    typedef struct {
        bit         s3;
        bit         wr;
        logic [1:0] a;
        logic [3:0] d;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd, d0;
        logic       rw;
        int         ws_cnt, bad, seen, acc_snap;

        ref1 = '{4'h3, 4'h6, 4'h9, 4'hC};
        ref3 = '{4'h3, 4'h6, 4'h9, 4'hC};
        vecs[0] = '{1'b0, 1'b1, 2'd1, 4'h5, 4'h0};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 4'h0, 4'h5};
        vecs[2] = '{1'b0, 1'b0, 2'd3, 4'h0, 4'hC};
        vecs[3] = '{1'b0, 1'b0, 2'd2, 4'h0, 4'hA};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 4'h9, 4'h0};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'h9};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 4'h0, 4'hC};
        vecs[7] = '{1'b1, 1'b1, 2'd3, 4'h7, 4'h0};
        vecs[8] = '{1'b1, 1'b0, 2'd3, 4'h0, 4'h7};

        // Reset with random request traffic.
        rst_n = 1'b0;
        repeat (2) begin
            scramble();
            v1 = 1'($urandom); v3 = 1'($urandom); t_rsp_ready = 1'($urandom);
            tick();
        end
        v1 = 1'b0; v3 = 1'b0; t_rsp_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            set_sel(s[0]);
            chk("reset req_ready",  32'(mon_req_ready), 1);
            chk("reset rsp_valid",  32'(mon_rsp_valid), 0);
            chk("reset rsp_write",  32'(mon_rsp_write), 0);
            chk("reset rsp_rdata",  32'(mon_rdata), 0);
            chk("reset word_sel",   32'(mon_word_sel), 0);
            chk("reset read_write", 32'(mon_rw), 1);
            chk("reset ram_in",     32'(mon_ram_in), 0);
        end
        rst_n  = 1'b1;
        inv_en = 1'b1;
        tick();

        // Write timing, one strobe cycle: write 0xA to address 2.
        set_sel(1'b0);
        t_write = 1'b1; t_addr = 2'd2; t_wdata = 4'hA; v1 = 1'b1;
        tick();
        v1 = 1'b0; exp_acc1++;
        scramble();
        chk("wt T+1 word_sel", 32'(mon_word_sel), 0);
        chk("wt T+1 read_write", 32'(mon_rw), 0);
        chk("wt T+1 ram_in", 32'(mon_ram_in), 32'hA);
        chk("wt T+1 req_ready", 32'(mon_req_ready), 0);
        tick();
        chk("wt T+2 word_sel", 32'(mon_word_sel), 32'b0100);
        chk("wt T+2 read_write", 32'(mon_rw), 0);
        chk("wt T+2 ram_in", 32'(mon_ram_in), 32'hA);
        tick();
        chk("wt T+3 word_sel", 32'(mon_word_sel), 0);
        chk("wt T+3 read_write", 32'(mon_rw), 0);
        chk("wt T+3 ram_in", 32'(mon_ram_in), 32'hA);
        chk("wt T+3 rsp_valid", 32'(mon_rsp_valid), 0);
        tick();
        chk("wt T+4 rsp_valid", 32'(mon_rsp_valid), 1);
        chk("wt T+4 rsp_write", 32'(mon_rsp_write), 1);
        chk("wt T+4 rsp_rdata", 32'(mon_rdata), 0);
        chk("wt T+4 read_write", 32'(mon_rw), 1);
        chk("wt T+4 ram_in", 32'(mon_ram_in), 0);
        tick();
        chk("wt T+5 rsp_valid", 32'(mon_rsp_valid), 0);
        chk("wt T+5 req_ready", 32'(mon_req_ready), 1);
        ref1[2] = 4'hA;

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].s3, vecs[i].wr, vecs[i].a, vecs[i].d, rd, rw);
            chk($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp));
            chk($sformatf("vec%0d rsp_write", i), 32'(rw), 32'(vecs[i].wr));
            if (vecs[i].wr) begin
                if (vecs[i].s3) ref3[vecs[i].a] = vecs[i].d; else ref1[vecs[i].a] = vecs[i].d;
            end
        end

        // Three strobe cycles, request held high, response back-pressured.
        set_sel(1'b1);
        t_write = 1'b0; t_addr = 2'd3; t_rsp_ready = 1'b0; v3 = 1'b1;
        tick();
        exp_acc3++;
        ws_cnt = 0; bad = 0;
        for (int n = 0; n < 20 && !mon_rsp_valid; n++) begin
            if (mon_word_sel != 0) ws_cnt++;
            if (mon_req_ready) bad++;
            tick();
        end
        chk("bp strobe cycles", 32'(ws_cnt), 3);
        chk("bp req_ready low while busy", 32'(bad), 0);
        d0 = mon_rdata;
        chk("bp rdata", 32'(d0), 32'(ref3[3]));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp hold%0d rsp_valid", i), 32'(mon_rsp_valid), 1);
            chk($sformatf("bp hold%0d rdata", i), 32'(mon_rdata), 32'(d0));
            chk($sformatf("bp hold%0d req_ready", i), 32'(mon_req_ready), 0);
            if (i < 4) tick();
        end
        t_rsp_ready = 1'b1;
        tick();
        chk("bp post rsp_valid", 32'(mon_rsp_valid), 0);
        chk("bp post req_ready", 32'(mon_req_ready), 1);
        chk("bp single accept", 32'(acc3), 32'(exp_acc3));
        v3 = 1'b0;
        tick();
        chk("bp no re-accept", 32'(acc3), 32'(exp_acc3));

        // Reset during the second strobe cycle of a read.
        t_write = 1'b0; t_addr = 2'd1; v3 = 1'b1;
        tick();
        v3 = 1'b0; exp_acc3++;
        tick();
        tick();
        chk("rst mid strobe sel", 32'(mon_word_sel), 32'b0010);
        rst_n = 1'b0;
        tick();
        chk("rst abort word_sel", 32'(mon_word_sel), 0);
        chk("rst abort read_write", 32'(mon_rw), 1);
        chk("rst abort req_ready", 32'(mon_req_ready), 1);
        chk("rst abort rsp_valid", 32'(mon_rsp_valid), 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (mon_rsp_valid) seen++;
        end
        chk("rst no response", 32'(seen), 0);

        // Address walk on both controllers.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 4; a++)
                model_op(s[0], 1'b1, 2'(a), 4'hF ^ 4'(a), $sformatf("walk w s%0d a%0d", s, a));
            for (int a = 0; a < 4; a++)
                model_op(s[0], 1'b0, 2'(a), 4'h0, $sformatf("walk r s%0d a%0d", s, a));
        end

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 40; i++) begin
            model_op(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                     $sformatf("rand%0d", i));
        end

        tick();
        acc_snap = acc1;
        chk("accept count S1", 32'(acc_snap), 32'(exp_acc1));
        chk("accept count S3", 32'(acc3), 32'(exp_acc3));

        inv_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
